// File: rtl/clk_rst_seq.sv
// Power-up / recovery sequencer for the DCM clock chain: pulses the DCM reset,
// waits for a stable lock, then releases the system reset; retries on failure.
module clk_rst_seq #(
    parameter int RST_PULSE     = 16,
    parameter int LOCK_TIMEOUT  = 65536,
    parameter int STABLE_CYCLES = 1024,
    parameter int MAX_RETRY     = 7
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clkLocked,
    output logic       dcmRst,
    output logic       sysRst,
    output logic       ready,
    output logic       fault,
    output logic [3:0] retryCount,
    output logic [7:0] lossCount,
    output logic [2:0] dbgState
);

    localparam int MAX_AB  = (RST_PULSE > LOCK_TIMEOUT) ? RST_PULSE : LOCK_TIMEOUT;
    localparam int CNT_MAX = (MAX_AB > STABLE_CYCLES) ? MAX_AB : STABLE_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] PULSE_LAST   = CNT_W'(RST_PULSE - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
    localparam logic [3:0]       RETRY_LIMIT  = 4'(MAX_RETRY);

    typedef enum logic [2:0] {
        S_RESET_DCM = 3'd0,
        S_WAIT_LOCK = 3'd1,
        S_STABLE    = 3'd2,
        S_RUN       = 3'd3,
        S_FAULT     = 3'd4
    } state_t;

    state_t           state;
    state_t           nextState;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cntNext;
    logic [3:0]       retryNext;
    logic [7:0]       lossNext;
    logic             attemptFailed;
    logic             lockMeta;
    logic             lockSync;
    logic             dcmRstNext;
    logic             sysRstNext;
    logic             readyNext;
    logic             faultNext;

    // clkLocked comes from another clock domain; nothing else may look at it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lockMeta <= 1'b0;
            lockSync <= 1'b0;
        end else begin
            lockMeta <= clkLocked;
            lockSync <= lockMeta;
        end
    end

    // State register; outputs are registered from the next state so they
    // change exactly on the edge that enters each state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_RESET_DCM;
            cnt        <= '0;
            retryCount <= 4'd0;
            lossCount  <= 8'd0;
            dcmRst     <= 1'b1;
            sysRst     <= 1'b1;
            ready      <= 1'b0;
            fault      <= 1'b0;
        end else begin
            state      <= nextState;
            cnt        <= cntNext;
            retryCount <= retryNext;
            lossCount  <= lossNext;
            dcmRst     <= dcmRstNext;
            sysRst     <= sysRstNext;
            ready      <= readyNext;
            fault      <= faultNext;
        end
    end

    // Next-state logic; the single counter is reused by every timed state.
    always_comb begin
        nextState     = state;
        cntNext       = cnt;
        retryNext     = retryCount;
        lossNext      = lossCount;
        attemptFailed = 1'b0;
        case (state)
            S_RESET_DCM: begin
                if (cnt == PULSE_LAST) begin
                    nextState = S_WAIT_LOCK;
                    cntNext   = '0;
                end else begin
                    cntNext = cnt + CNT_ONE;
                end
            end
            S_WAIT_LOCK: begin
                // Lock wins over a timeout landing on the same cycle.
                if (lockSync) begin
                    nextState = S_STABLE;
                    cntNext   = '0;
                end else if (cnt == TIMEOUT_LAST) begin
                    attemptFailed = 1'b1;
                end else begin
                    cntNext = cnt + CNT_ONE;
                end
            end
            S_STABLE: begin
                if (!lockSync) begin
                    attemptFailed = 1'b1;
                end else if (cnt == STABLE_LAST) begin
                    nextState = S_RUN;
                    cntNext   = '0;
                    retryNext = 4'd0;
                end else begin
                    cntNext = cnt + CNT_ONE;
                end
            end
            S_RUN: begin
                if (!lockSync) begin
                    nextState = S_RESET_DCM;
                    cntNext   = '0;
                    if (lossCount != 8'hFF) begin
                        lossNext = lossCount + 8'd1;
                    end
                end
            end
            S_FAULT: begin
                nextState = S_FAULT;
            end
            default: begin
                nextState = S_RESET_DCM;
                cntNext   = '0;
            end
        endcase

        if (attemptFailed) begin
            cntNext = '0;
            if (retryCount == RETRY_LIMIT) begin
                nextState = S_FAULT;
            end else begin
                nextState = S_RESET_DCM;
                retryNext = retryCount + 4'd1;
            end
        end
    end

    always_comb begin
        dcmRstNext = (nextState == S_RESET_DCM) || (nextState == S_FAULT);
        sysRstNext = (nextState != S_RUN);
        readyNext  = (nextState == S_RUN);
        faultNext  = (nextState == S_FAULT);
    end

    assign dbgState = state;

endmodule

// File: tb/tb_clk_rst_seq.sv
// Bench for clk_rst_seq: a countdown-based phase model predicts every output
// each cycle while directed and random clkLocked patterns are applied.
module tb_clk_rst_seq;

    localparam int RST_PULSE     = 4;
    localparam int LOCK_TIMEOUT  = 32;
    localparam int STABLE_CYCLES = 16;
    localparam int MAX_RETRY     = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       clkLocked = 1'b0;
    logic       dcmRst;
    logic       sysRst;
    logic       ready;
    logic       fault;
    logic [3:0] retryCount;
    logic [7:0] lossCount;
    logic [2:0] dbgState;

    int checks = 0;
    int errors = 0;
    bit chkEn  = 1'b0;

    clk_rst_seq #(
        .RST_PULSE    (RST_PULSE),
        .LOCK_TIMEOUT (LOCK_TIMEOUT),
        .STABLE_CYCLES(STABLE_CYCLES),
        .MAX_RETRY    (MAX_RETRY)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .clkLocked (clkLocked),
        .dcmRst    (dcmRst),
        .sysRst    (sysRst),
        .ready     (ready),
        .fault     (fault),
        .retryCount(retryCount),
        .lossCount (lossCount),
        .dbgState  (dbgState)
    );

    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference model: each phase knows how many cycles it has left.
    typedef enum int {PH_PULSE, PH_WAIT, PH_SETTLE, PH_LIVE, PH_DEAD} phase_t;
    phase_t ph    = PH_PULSE;
    int     left  = RST_PULSE;
    int     mRetry = 0;
    int     mLoss  = 0;
    bit     syncQ[$] = '{1'b0, 1'b0};

    function automatic void modelReset();
        ph     = PH_PULSE;
        left   = RST_PULSE;
        mRetry = 0;
        mLoss  = 0;
        syncQ  = '{1'b0, 1'b0};
    endfunction

    function automatic void failedAttempt();
        if (mRetry == MAX_RETRY) begin
            ph = PH_DEAD;
        end else begin
            mRetry++;
            ph   = PH_PULSE;
            left = RST_PULSE;
        end
    endfunction

    always @(posedge clk or posedge rst) begin
        bit seen;
        if (rst) begin
            modelReset();
        end else begin
            seen = syncQ.pop_front();
            syncQ.push_back(clkLocked);
            case (ph)
                PH_PULSE: begin
                    left--;
                    if (left == 0) begin
                        ph   = PH_WAIT;
                        left = LOCK_TIMEOUT;
                    end
                end
                PH_WAIT: begin
                    if (seen) begin
                        ph   = PH_SETTLE;
                        left = STABLE_CYCLES;
                    end else begin
                        left--;
                        if (left == 0) failedAttempt();
                    end
                end
                PH_SETTLE: begin
                    if (!seen) begin
                        failedAttempt();
                    end else begin
                        left--;
                        if (left == 0) begin
                            ph     = PH_LIVE;
                            mRetry = 0;
                        end
                    end
                end
                PH_LIVE: begin
                    if (!seen) begin
                        if (mLoss < 255) mLoss++;
                        ph   = PH_PULSE;
                        left = RST_PULSE;
                    end
                end
                default: ;
            endcase
        end
    end

    // Scoreboard: every output against the model on each falling edge.
    always @(negedge clk) begin
        if (chkEn) begin
            checkVal("dcmRst", dcmRst, (ph == PH_PULSE) || (ph == PH_DEAD));
            checkVal("sysRst", sysRst, ph != PH_LIVE);
            checkVal("ready", ready, ph == PH_LIVE);
            checkVal("fault", fault, ph == PH_DEAD);
            checkVal("retryCount", retryCount, mRetry);
            checkVal("lossCount", lossCount, mLoss);
        end
    end

    task automatic tick(input logic v);
        @(negedge clk);
        #1 clkLocked = v;
    endtask

    task automatic waitPhase(input phase_t p, input int budget, input string tag);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (ph == p) begin
                hit = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!hit) checkVal(tag, 0, 1);
    endtask

    task automatic pulseRst(input string tag);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checkVal({tag, "_dcmRst"}, dcmRst, 1);
        checkVal({tag, "_sysRst"}, sysRst, 1);
        checkVal({tag, "_ready"}, ready, 0);
        checkVal({tag, "_fault"}, fault, 0);
        checkVal({tag, "_retry"}, retryCount, 0);
        checkVal({tag, "_loss"}, lossCount, 0);
        @(negedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic countRun(input logic lvl, output int n);
        n = 0;
        for (int i = 0; i < 200; i++) begin
            if (dcmRst !== lvl) break;
            n++;
            @(negedge clk);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got 0 expected 1");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int  n;
        int  lat;
        bit  hit;
        int  len;
        logic v;

        #1 rst = 1'b1;
        chkEn = 1'b1;
        repeat (2) @(negedge clk);
        #1 rst = 1'b0;

        // Nominal bring-up
        repeat (10) tick(1'b0);
        tick(1'b1);
        waitPhase(PH_LIVE, 100, "nomReachRun");
        checkVal("nomRetry", retryCount, 0);
        checkVal("nomReady", ready, 1);

        // Lock loss in RUN
        tick(1'b0);
        lat = 0;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            if (!ready) begin
                lat = i;
                break;
            end
        end
        checkVal("lossLatency", lat, 3);
        checkVal("lossSysRst", sysRst, 1);
        checkVal("lossCount1", lossCount, 1);
        #1 clkLocked = 1'b1;
        waitPhase(PH_LIVE, 100, "relockRun");
        checkVal("relockRetry", retryCount, 0);

        // One-cycle glitch in the middle of STABLE
        repeat (3) tick(1'b0);
        #1 clkLocked = 1'b1;
        waitPhase(PH_SETTLE, 60, "glitchSettle");
        repeat (8) tick(1'b1);
        tick(1'b0);
        tick(1'b1);
        waitPhase(PH_PULSE, 10, "glitchPulse");
        checkVal("glitchRetry", retryCount, 1);
        checkVal("glitchSysRst", sysRst, 1);
        waitPhase(PH_LIVE, 100, "glitchRecover");

        // Lock arriving on the timeout cycle of WAIT_LOCK
        tick(1'b0);
        hit = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (ph == PH_WAIT && mRetry == 1 && left == 3) begin
                hit = 1'b1;
                break;
            end
        end
        if (!hit) checkVal("raceSetup", 0, 1);
        #1 clkLocked = 1'b1;
        repeat (3) @(negedge clk);
        checkVal("raceDcm", dcmRst, 0);
        checkVal("raceRetry", retryCount, 1);
        waitPhase(PH_LIVE, 60, "raceRun");

        // Asynchronous reset while running
        pulseRst("rstInRun");
        clkLocked = 1'b0;

        // No lock at all: retries then fault
        hit = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (dcmRst === 1'b0) begin
                hit = 1'b1;
                break;
            end
        end
        if (!hit) checkVal("noLockFirstFall", 0, 1);
        for (int p = 1; p <= MAX_RETRY; p++) begin
            countRun(1'b0, n);
            checkVal("noLockGap", n, LOCK_TIMEOUT);
            checkVal("noLockRetry", retryCount, p);
            countRun(1'b1, n);
            checkVal("noLockPulse", n, RST_PULSE);
        end
        countRun(1'b0, n);
        checkVal("noLockLastGap", n, LOCK_TIMEOUT);
        checkVal("faultSet", fault, 1);
        checkVal("faultDcm", dcmRst, 1);
        repeat (20) tick(1'b1);
        checkVal("faultTerminal", fault, 1);
        checkVal("faultSysRst", sysRst, 1);

        // Asynchronous reset out of FAULT
        pulseRst("rstInFault");
        waitPhase(PH_LIVE, 100, "afterFaultRun");
        checkVal("afterFaultReady", ready, 1);

        // Random lock patterns with occasional resets
        for (int it = 0; it < 60; it++) begin
            if ($urandom_range(0, 9) == 0) begin
                pulseRst("rstRand");
            end else begin
                v   = 1'($urandom_range(0, 1));
                len = v ? $urandom_range(1, 40) : $urandom_range(1, 12);
                repeat (len) tick(v);
            end
        end
        repeat (5) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
